// File: rtl/etc_pkg.sv
// Shared definitions for the ETC decode scheduler.
// Holds bus widths, the scheduler FSM encoding and the latched block payload.
package etc_pkg;

    localparam int unsigned BLOCK_W          = 64;
    localparam int unsigned TEXELS_PER_BLOCK = 16;
    localparam int unsigned RGBA_W           = 32;
    localparam int unsigned PIX_W            = 4;
    localparam int unsigned COORD_W          = 8;
    localparam int unsigned WIDTH_W          = 16;
    localparam int unsigned ADDR_W           = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BLK = 3'd1,
        ST_DECODE   = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_HOLDOFF  = 3'd5,
        ST_DONE     = 3'd6
    } sched_state_e;

    // Compressed block and its position in block units, as latched from the fetcher.
    typedef struct packed {
        logic [BLOCK_W-1:0] data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } blk_info_t;

endpackage

// File: rtl/etc_texel_addr_calc.sv
// Frame-buffer byte address of one texel of a 4x4 block (combinational).
// Ports:
//   blk_x_i, blk_y_i  block coordinates in block units
//   pix_i             texel index 0..15, column-major inside the block
//   img_width_i       image width in texels
//   addr_o            BASE_ADDR + ((ty*img_width + tx) << BPP_SHIFT), mod 2^32
module etc_texel_addr_calc
    import etc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       BPP_SHIFT = 2
) (
    input  logic [COORD_W-1:0] blk_x_i,
    input  logic [COORD_W-1:0] blk_y_i,
    input  logic [PIX_W-1:0]   pix_i,
    input  logic [WIDTH_W-1:0] img_width_i,
    output logic [ADDR_W-1:0]  addr_o
);

    logic [ADDR_W-1:0] tx;
    logic [ADDR_W-1:0] ty;
    logic [ADDR_W-1:0] lin;

    // Block coordinate times 4 plus the in-block offset is a plain concatenation.
    always_comb begin
        tx     = ADDR_W'({blk_x_i, pix_i[3:2]});
        ty     = ADDR_W'({blk_y_i, pix_i[1:0]});
        lin    = ty * ADDR_W'(img_width_i) + tx;
        addr_o = BASE_ADDR + (lin << BPP_SHIFT);
    end

endmodule

// File: rtl/etc_decode_scheduler.sv
// ETC decode scheduler: walks the 16 texels of each fetched block through the
// texel decoder and writes the decoded RGBA values to the frame buffer.
// Ports:
//   sclk, rsrt                  clock, async active-low reset
//   start, busy, frame_done     frame control and status
//   img_width                   image width in texels
//   blk_valid/data/x/y          block from the fetcher; write_finish releases it
//   image_finished              fetcher has no more blocks
//   dec_req/block/pix, dec_valid/rgba   decoder request / response
//   mem_req/addr/wdata, mem_ack         frame-buffer write request / accept
module etc_decode_scheduler
    import etc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       BPP_SHIFT = 2
) (
    input  logic               sclk,
    input  logic               rsrt,
    input  logic               start,
    input  logic [WIDTH_W-1:0] img_width,
    input  logic               blk_valid,
    input  logic [BLOCK_W-1:0] blk_data,
    input  logic [COORD_W-1:0] blk_x,
    input  logic [COORD_W-1:0] blk_y,
    input  logic               image_finished,
    output logic               write_finish,
    output logic               dec_req,
    output logic [BLOCK_W-1:0] dec_block,
    output logic [PIX_W-1:0]   dec_pix,
    input  logic               dec_valid,
    input  logic [RGBA_W-1:0]  dec_rgba,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [RGBA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TEXELS_PER_BLOCK - 1);

    sched_state_e      state_q, state_d;
    blk_info_t         blk_q, blk_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              dec_req_q, dec_req_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [RGBA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              write_finish_q, write_finish_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] texel_addr;

    etc_texel_addr_calc #(
        .BASE_ADDR (BASE_ADDR),
        .BPP_SHIFT (BPP_SHIFT)
    ) u_addr_calc (
        .blk_x_i     (blk_q.x),
        .blk_y_i     (blk_q.y),
        .pix_i       (pix_q),
        .img_width_i (img_width),
        .addr_o      (texel_addr)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        blk_d          = blk_q;
        pix_d          = pix_q;
        dec_req_d      = dec_req_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        busy_d         = busy_q;
        write_finish_d = 1'b0;
        frame_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_BLK;
                end
            end
            ST_WAIT_BLK: begin
                // A pending block takes priority over end-of-image.
                if (blk_valid) begin
                    blk_d.data = blk_data;
                    blk_d.x    = blk_x;
                    blk_d.y    = blk_y;
                    pix_d      = '0;
                    dec_req_d  = 1'b1;
                    state_d    = ST_DECODE;
                end else if (image_finished) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DECODE: begin
                if (dec_valid) begin
                    dec_req_d   = 1'b0;
                    mem_wdata_d = dec_rgba;
                    mem_addr_d  = texel_addr;
                    mem_req_d   = 1'b1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (pix_q == LAST_PIX) begin
                        write_finish_d = 1'b1;
                        state_d        = ST_RELEASE;
                    end else begin
                        pix_d     = pix_q + PIX_W'(1);
                        dec_req_d = 1'b1;
                        state_d   = ST_DECODE;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                // Wait for the fetcher to drop the released block so it is not re-accepted.
                if (!blk_valid) begin
                    state_d = ST_WAIT_BLK;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            state_q        <= ST_IDLE;
            blk_q          <= '0;
            pix_q          <= '0;
            dec_req_q      <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            write_finish_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            blk_q          <= blk_d;
            pix_q          <= pix_d;
            dec_req_q      <= dec_req_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            write_finish_q <= write_finish_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign write_finish = write_finish_q;
    assign dec_req      = dec_req_q;
    assign dec_block    = blk_q.data;
    assign dec_pix      = pix_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_etc_decode_scheduler.sv
// Bench for etc_decode_scheduler: two instances in lockstep (base 0 and a
// wrapping base), a decoder/memory responder with programmable latency and a
// write scoreboard checked whenever a frame-buffer write is accepted.
`timescale 1ns/1ps
module tb_etc_decode_scheduler;
    import etc_pkg::*;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFF0;

    typedef struct {
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [31:0] data;
        logic [3:0]  pix;
    } exp_t;

    logic        sclk = 1'b0;
    logic        rsrt = 1'b1;
    logic        start = 1'b0;
    logic [15:0] img_width = 16'd128;
    logic        blk_valid = 1'b0;
    logic [63:0] blk_data = '0;
    logic [7:0]  blk_x = '0;
    logic [7:0]  blk_y = '0;
    logic        image_finished = 1'b0;
    logic        dec_valid = 1'b0;
    logic [31:0] dec_rgba = '0;
    logic        mem_ack = 1'b0;

    logic        write_finish_a, dec_req_a, mem_req_a, busy_a, frame_done_a;
    logic [63:0] dec_block_a;
    logic [3:0]  dec_pix_a;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic        write_finish_b, dec_req_b, mem_req_b, busy_b, frame_done_b;
    logic [63:0] dec_block_b;
    logic [3:0]  dec_pix_b;
    logic [31:0] mem_addr_b, mem_wdata_b;

    int n_vec = 0;
    int n_err = 0;
    int dec_lat = 0;
    int ack_lat = 0;
    int dec_cnt = 0;
    int ack_cnt = 0;
    int wf_pulses = 0;
    int fd_pulses = 0;
    exp_t sb_q[$];
    logic [31:0] cap_a [16];
    logic [31:0] cap_b [16];
    logic [71:0] dec_snap;
    logic [71:0] mem_snap;

    etc_decode_scheduler #(.BASE_ADDR(BASE_A), .BPP_SHIFT(2)) u_dut_a (
        .sclk(sclk), .rsrt(rsrt), .start(start), .img_width(img_width),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_x(blk_x), .blk_y(blk_y),
        .image_finished(image_finished), .write_finish(write_finish_a),
        .dec_req(dec_req_a), .dec_block(dec_block_a), .dec_pix(dec_pix_a),
        .dec_valid(dec_valid), .dec_rgba(dec_rgba),
        .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ack(mem_ack), .busy(busy_a), .frame_done(frame_done_a)
    );

    etc_decode_scheduler #(.BASE_ADDR(BASE_B), .BPP_SHIFT(2)) u_dut_b (
        .sclk(sclk), .rsrt(rsrt), .start(start), .img_width(img_width),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_x(blk_x), .blk_y(blk_y),
        .image_finished(image_finished), .write_finish(write_finish_b),
        .dec_req(dec_req_b), .dec_block(dec_block_b), .dec_pix(dec_pix_b),
        .dec_valid(dec_valid), .dec_rgba(dec_rgba),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ack(mem_ack), .busy(busy_b), .frame_done(frame_done_b)
    );

    always #5 sclk = ~sclk;

    function automatic logic [31:0] rgba_of(input logic [63:0] blk, input logic [3:0] pix);
        return blk[31:0] ^ blk[63:32] ^ {8{pix}};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [15:0] w,
                                             input logic [7:0] bx, input logic [7:0] by,
                                             input logic [3:0] pix);
        logic [31:0] tx, ty;
        tx = 32'(bx) * 32'd4 + 32'(pix[3:2]);
        ty = 32'(by) * 32'd4 + 32'(pix[1:0]);
        return base + ((ty * 32'(w) + tx) * 32'd4);
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_a"}, {write_finish_a, dec_req_a, mem_req_a, busy_a, frame_done_a,
                             dec_pix_a, |dec_block_a, |mem_addr_a, |mem_wdata_a}, '0);
        check({name, "_b"}, {write_finish_b, dec_req_b, mem_req_b, busy_b, frame_done_b,
                             dec_pix_b, |dec_block_b, |mem_addr_b, |mem_wdata_b}, '0);
    endtask

    // Decoder and memory responders plus write scoreboard, all on the falling edge.
    always @(negedge sclk) begin
        exp_t e;
        if (write_finish_a) wf_pulses++;
        if (frame_done_a) fd_pulses++;

        if (dec_req_a) begin
            if (dec_cnt == 0) dec_snap = 72'({dec_block_a, dec_pix_a});
            dec_valid = (dec_cnt == dec_lat);
            dec_rgba  = dec_valid ? rgba_of(dec_block_a, dec_pix_a) : 32'hDEAD_BEEF;
            if (dec_valid && dec_lat > 0) check("dec_hold", 72'({dec_block_a, dec_pix_a}), dec_snap);
            dec_cnt++;
        end else begin
            dec_valid = 1'b0;
            dec_cnt   = 0;
        end

        if (mem_req_a) begin
            if (ack_cnt == 0) mem_snap = 72'({mem_addr_a, mem_wdata_a});
            mem_ack = (ack_cnt == ack_lat);
            if (mem_ack) begin
                if (ack_lat > 0) check("mem_hold", 72'({mem_addr_a, mem_wdata_a}), mem_snap);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr 0x%h, expected no write", mem_addr_a);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_pix", 72'(dec_pix_a), 72'(e.pix));
                    check("wr_addr", 72'(mem_addr_a), 72'(e.addr_a));
                    check("wr_addr_wrap", 72'(mem_addr_b), 72'(e.addr_b));
                    check("wr_data", 72'(mem_wdata_a), 72'(e.data));
                    cap_a[e.pix] = mem_addr_a;
                    cap_b[e.pix] = mem_addr_b;
                end
            end
            ack_cnt++;
        end else begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end
    end

    task automatic push_block(input logic [7:0] bx, input logic [7:0] by, input logic [63:0] data);
        for (int p = 0; p < 16; p++) begin
            exp_t e;
            e.pix    = 4'(p);
            e.addr_a = exp_addr(BASE_A, img_width, bx, by, 4'(p));
            e.addr_b = exp_addr(BASE_B, img_width, bx, by, 4'(p));
            e.data   = rgba_of(data, 4'(p));
            sb_q.push_back(e);
        end
    endtask

    task automatic do_start();
        @(negedge sclk);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        check("busy_after_start", 72'(busy_a), 72'(1));
    endtask

    task automatic run_block(input logic [7:0] bx, input logic [7:0] by, input logic [63:0] data,
                             input int hold, input int exp_cycles);
        int cyc;
        int wf0;
        int req_seen;
        push_block(bx, by, data);
        wf0 = wf_pulses;
        @(negedge sclk);
        blk_valid = 1'b1;
        blk_data  = data;
        blk_x     = bx;
        blk_y     = by;
        cyc = 0;
        while (!write_finish_a && cyc < 400) begin
            @(negedge sclk);
            cyc++;
        end
        check("blk_release_seen", 72'(write_finish_a), 72'(1));
        check("blk_cycles", 72'(cyc), 72'(exp_cycles));
        req_seen = 0;
        repeat (hold) begin
            @(negedge sclk);
            if (dec_req_a || mem_req_a) req_seen++;
        end
        blk_valid = 1'b0;
        repeat (3) begin
            @(negedge sclk);
            if (dec_req_a || mem_req_a) req_seen++;
        end
        check("no_reaccept", 72'(req_seen), 72'(0));
        check("wf_pulses", 72'(wf_pulses - wf0), 72'(1));
        check("sb_drained", 72'(sb_q.size()), 72'(0));
    endtask

    task automatic end_frame(input logic pulse_start);
        int cyc;
        int f0;
        f0 = fd_pulses;
        @(negedge sclk);
        image_finished = 1'b1;
        start = pulse_start;
        cyc = 0;
        while (!frame_done_a && cyc < 20) begin
            @(negedge sclk);
            start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        image_finished = 1'b0;
        check("frame_done_seen", 72'(frame_done_a), 72'(1));
        check("busy_at_done", 72'(busy_a), 72'(1));
        @(negedge sclk);
        check("frame_done_width", 72'(frame_done_a), 72'(0));
        check("busy_after_done", 72'(busy_a), 72'(0));
        repeat (3) @(negedge sclk);
        check("busy_stays_low", 72'(busy_a), 72'(0));
        check("fd_pulses", 72'(fd_pulses - f0), 72'(1));
    endtask

    initial begin
        int cyc;
        #3 rsrt = 1'b0;
        #1 check_zero("reset_state");
        repeat (2) @(negedge sclk);
        rsrt = 1'b1;

        // Block (2,1), zero-latency decoder and memory.
        do_start();
        run_block(8'd2, 8'd1, 64'h0123_4567_89AB_CDEF, 0, 33);
        check("addr_pix0", 72'(cap_a[0]), 72'(32'h0000_0820));
        check("addr_pix5", 72'(cap_a[5]), 72'(32'h0000_0A24));
        check("addr_pix15", 72'(cap_a[15]), 72'(32'h0000_0E2C));

        // Block (0,0), slow decoder and memory, fetcher keeps blk_valid high after release.
        dec_lat = 3;
        ack_lat = 2;
        run_block(8'd0, 8'd0, 64'hFEDC_BA98_7654_3210, 4, 113);
        dec_lat = 0;
        ack_lat = 0;
        check("addr_pix12", 72'(cap_a[12]), 72'(32'h0000_000C));
        check("wrap_pix4", 72'(cap_b[4]), 72'(32'hFFFF_FFF4));
        check("wrap_pix8", 72'(cap_b[8]), 72'(32'hFFFF_FFF8));
        check("wrap_pix12", 72'(cap_b[12]), 72'(32'hFFFF_FFFC));
        check("wrap_pix1", 72'(cap_b[1]), 72'(32'h0000_01F0));

        // End of image with a start pulse while busy.
        end_frame(1'b1);

        // Reset in the middle of a block at texel 7.
        do_start();
        push_block(8'd3, 8'd2, 64'h1111_2222_3333_4444);
        @(negedge sclk);
        blk_valid = 1'b1;
        blk_data  = 64'h1111_2222_3333_4444;
        blk_x     = 8'd3;
        blk_y     = 8'd2;
        cyc = 0;
        while (!(mem_req_a && dec_pix_a == 4'd7) && cyc < 100) begin
            @(negedge sclk);
            cyc++;
        end
        check("reached_pix7", 72'({mem_req_a, dec_pix_a}), 72'({1'b1, 4'd7}));
        #2 rsrt = 1'b0;
        blk_valid = 1'b0;
        #1 check_zero("reset_mid_block");
        sb_q.delete();
        repeat (2) @(negedge sclk);
        rsrt = 1'b1;
        repeat (3) @(negedge sclk);
        check("no_autostart", 72'({busy_a, dec_req_a}), 72'(0));

        do_start();
        run_block(8'd3, 8'd2, 64'h5555_6666_7777_8888, 0, 33);
        end_frame(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
